td4_inst_decoder: RTL and testbench
===================================

Name: td4_inst_decoder

Overview:
- Instruction decoder for the TD4 4-bit CPU. Maps the 4-bit opcode field and the carry flag to active-low register load enables and the 2-bit ALU source-mux select.
- The decode path is purely combinational, with zero latency.
- A small clocked status section records undefined opcodes.
- Sits between the ROM/opcode field and the A, B, OUT and PC register load inputs and the source mux.

Parameters:
- UNDEF_SELECT, 2'b11, select value driven for undefined opcodes.

Ports:
- clk  input  1  system clock; only the status register uses it.
- reset  input  1  asynchronous, active-high reset.
- op  input  4  opcode, instruction bits [7:4].
- carry_n  input  1  carry flag from the flag register. 0 = no carry on the previous ADD, so JNC is taken. 1 = carry, so JNC is not taken.
- load_n  output  4  active-low load enables: [0]=A, [1]=B, [2]=OUT, [3]=PC.
- select  output  2  source mux select: 00=A, 01=B, 10=IN port, 11=zero (immediate only).
- illegal  output  1  sticky flag, set after any undefined opcode is decoded.

Behaviour:
- load_n and select are combinational functions of op and carry_n. They change in the same delta as the inputs.
- carry_n affects outputs only for op=1110. For every other op the outputs must be fully defined even if carry_n is X.
- Decode table (op -> load_n, select):
  - 0000 ADD A,Im -> 1110, 00
  - 0001 MOV A,B -> 1110, 01
  - 0010 IN A -> 1110, 10
  - 0011 MOV A,Im -> 1110, 11
  - 0100 MOV B,A -> 1101, 00
  - 0101 ADD B,Im -> 1101, 01
  - 0110 IN B -> 1101, 10
  - 0111 MOV B,Im -> 1101, 11
  - 1001 OUT B -> 1011, 01
  - 1011 OUT Im -> 1011, 11
  - 1110 JNC -> 0111, 11 when carry_n=0; 1111, 11 when carry_n=1
  - 1111 JMP -> 0111, 11
- Undefined ops are 1000, 1010, 1100 and 1101. Each decodes as a NOP: load_n=1111, select=UNDEF_SELECT.
- At most one load_n bit is ever low.
- illegal:
  - Cleared to 0 asynchronously while reset=1.
  - Set to 1 on a rising clk edge where op is undefined; stays set until reset.
  - If reset is asserted mid-run, illegal clears immediately. The combinational outputs keep decoding during reset.

Optional Feature:
- Macro: TD4_DECODER_ILLEGAL_TRAP_EN.
- With the macro defined: while illegal=1, load_n is forced to 1111 regardless of op, freezing the CPU until reset. select still decodes normally.
- Without the macro: illegal is status only and never alters load_n.

Test Plan:
- Sweep op over 0000..0111 with carry_n=X -> load_n 1110 for op[2]=0 and 1101 for op[2]=1; select equals op[1:0]; no X on outputs.
- op=1001 -> load_n=1011, select=01. op=1011 -> load_n=1011, select=11.
- op=1110 with carry_n=0 -> load_n=0111. Change carry_n to 1 -> load_n=1111 in the same delta. select=11 throughout.
- op=1111 with carry_n=X -> load_n=0111, select=11.
- Release reset, apply op=1010 for one clk edge, then op=0000 -> load_n=1111/select=11 while 1010 is applied. illegal=1 after the edge and stays 1. Asserting reset clears illegal with no clock needed.
- With TD4_DECODER_ILLEGAL_TRAP_EN defined and illegal=1, apply op=0000 -> load_n=1111 until reset.

Source files
------------

// File: rtl/td4_inst_decoder_if.sv
// Decoder-side bus for the TD4 instruction decoder: opcode/carry in, load enables, mux select and status out.
// The master drives op/carry_n (ROM + flag register side); the slave is the decoder.
interface td4_inst_decoder_if;
    logic [3:0] op;
    logic       carry_n;
    logic [3:0] load_n;
    logic [1:0] select;
    logic       illegal;

    modport master (
        output op,
        output carry_n,
        input  load_n,
        input  select,
        input  illegal
    );

    modport slave (
        input  op,
        input  carry_n,
        output load_n,
        output select,
        output illegal
    );
endinterface

// File: rtl/td4_inst_decoder.sv
// TD4 instruction decoder: combinational opcode -> load_n/select, plus a sticky undefined-opcode flag.
// Optional macro TD4_DECODER_ILLEGAL_TRAP_EN: once illegal is set, all loads are held off until reset.
module td4_inst_decoder #(
    parameter logic [1:0] UNDEF_SELECT = 2'b11
) (
    input  logic              clk,
    input  logic              reset,
    td4_inst_decoder_if.slave dec
);

    localparam logic [3:0] LOAD_NONE = 4'b1111;
    localparam logic [3:0] LOAD_A    = 4'b1110;
    localparam logic [3:0] LOAD_B    = 4'b1101;
    localparam logic [3:0] LOAD_OUT  = 4'b1011;
    localparam logic [3:0] LOAD_PC   = 4'b0111;

    localparam logic [1:0] SEL_B     = 2'b01;
    localparam logic [1:0] SEL_ZERO  = 2'b11;

    logic [3:0] dec_load_n;
    logic [1:0] dec_select;
    logic       op_undef;
    logic       illegal_q;

    // carry_n is read only in the JNC arm so an unknown carry never leaks into other opcodes.
    always_comb begin
        dec_load_n = LOAD_NONE;
        dec_select = UNDEF_SELECT;
        op_undef   = 1'b0;
        case (dec.op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                dec_load_n = LOAD_A;
                dec_select = dec.op[1:0];
            end
            4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                dec_load_n = LOAD_B;
                dec_select = dec.op[1:0];
            end
            4'b1001: begin
                dec_load_n = LOAD_OUT;
                dec_select = SEL_B;
            end
            4'b1011: begin
                dec_load_n = LOAD_OUT;
                dec_select = SEL_ZERO;
            end
            4'b1110: begin
                dec_load_n = dec.carry_n ? LOAD_NONE : LOAD_PC;
                dec_select = SEL_ZERO;
            end
            4'b1111: begin
                dec_load_n = LOAD_PC;
                dec_select = SEL_ZERO;
            end
            default: begin
                op_undef = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (op_undef) begin
            illegal_q <= 1'b1;
        end
    end

`ifdef TD4_DECODER_ILLEGAL_TRAP_EN
    assign dec.load_n = illegal_q ? LOAD_NONE : dec_load_n;
`else
    assign dec.load_n = dec_load_n;
`endif

    assign dec.select  = dec_select;
    assign dec.illegal = illegal_q;

endmodule

// File: tb/tb_td4_inst_decoder.sv
// Bench for td4_inst_decoder: fixed decode table, hand-written illegal/reset sequence, then random
// opcodes checked against an instruction-set level reference model.
module tb_td4_inst_decoder;

  localparam logic [1:0] UNDEF_SEL = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_illegal;
  logic [6:0] exp_q[$];

  td4_inst_decoder_if dec_if ();

  td4_inst_decoder #(.UNDEF_SELECT(UNDEF_SEL)) dut (
    .clk   (clk),
    .reset (reset),
    .dec   (dec_if.slave)
  );

  always #5 clk = ~clk;

  // Instruction set view: mnemonic, destination register (0=A 1=B 2=OUT 3=PC, -1 none) and ALU source.
  string mnem[16];
  int    dest_of[16];
  int    src_of[16];

  typedef struct {
    logic [3:0] op;
    logic       carry_n;
    logic [3:0] load_n;
    logic [1:0] select;
  } vec_t;

  vec_t vecs[18];

  function automatic logic is_defined(input logic [3:0] op);
    return mnem[op] != "";
  endfunction

  function automatic logic [5:0] ref_decode(input logic [3:0] op, input logic carry_n);
    logic [3:0] ln;
    int d;
    ln = 4'b1111;
    d  = dest_of[op];
    // JNC only writes the PC when the previous ADD left no carry.
    if (d >= 0 && !(mnem[op] == "JNC" && carry_n == 1'b1)) ln[d[1:0]] = 1'b0;
`ifdef TD4_DECODER_ILLEGAL_TRAP_EN
    if (exp_illegal) ln = 4'b1111;
`endif
    return {ln, src_of[op][1:0]};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (op=%b carry_n=%b t=%0t)",
               name, act, exp, dec_if.op, dec_if.carry_n, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [6:0] e;
    e = exp_q.pop_front();
    check({tag, " load_n"}, dec_if.load_n, e[6:3]);
    check({tag, " select"}, {2'b00, dec_if.select}, {2'b00, e[2:1]});
    check({tag, " illegal"}, {3'b000, dec_if.illegal}, {3'b000, e[0]});
  endtask

  task automatic drive(input logic [3:0] op, input logic carry_n);
    dec_if.op      = op;
    dec_if.carry_n = carry_n;
  endtask

  initial begin
    mnem    = '{"ADD A,Im", "MOV A,B", "IN A", "MOV A,Im", "MOV B,A", "ADD B,Im", "IN B", "MOV B,Im",
                "", "OUT B", "", "OUT Im", "", "", "JNC", "JMP"};
    dest_of = '{0, 0, 0, 0, 1, 1, 1, 1, -1, 2, -1, 2, -1, -1, 3, 3};
    src_of  = '{0, 1, 2, 3, 0, 1, 2, 3, 3, 1, 3, 3, 3, 3, 3, 3};

    vecs = '{
      '{4'b0000, 1'bx, 4'b1110, 2'b00}, '{4'b0001, 1'bx, 4'b1110, 2'b01},
      '{4'b0010, 1'bx, 4'b1110, 2'b10}, '{4'b0011, 1'bx, 4'b1110, 2'b11},
      '{4'b0100, 1'bx, 4'b1101, 2'b00}, '{4'b0101, 1'bx, 4'b1101, 2'b01},
      '{4'b0110, 1'bx, 4'b1101, 2'b10}, '{4'b0111, 1'bx, 4'b1101, 2'b11},
      '{4'b1001, 1'bx, 4'b1011, 2'b01}, '{4'b1011, 1'bx, 4'b1011, 2'b11},
      '{4'b1110, 1'b0, 4'b0111, 2'b11}, '{4'b1110, 1'b1, 4'b1111, 2'b11},
      '{4'b1111, 1'bx, 4'b0111, 2'b11}, '{4'b1111, 1'b1, 4'b0111, 2'b11},
      '{4'b1000, 1'b0, 4'b1111, 2'b11}, '{4'b1010, 1'b1, 4'b1111, 2'b11},
      '{4'b1100, 1'b0, 4'b1111, 2'b11}, '{4'b1101, 1'b1, 4'b1111, 2'b11}
    };

    // Clock/reset: the table runs with reset held, so illegal stays clear and decode is undisturbed.
    exp_illegal = 1'b0;
    reset = 1'b1;
    drive(4'b0000, 1'b0);
    #3;
    check("reset illegal", {3'b000, dec_if.illegal}, 4'b0000);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].carry_n);
      #1;
      exp_q.push_back({vecs[i].load_n, vecs[i].select, 1'b0});
      check_all($sformatf("table[%0d]", i));
    end

    // JNC: carry_n flip alone must move load_n without any clock.
    @(negedge clk);
    drive(4'b1110, 1'b0);
    #1;
    check("jnc taken", dec_if.load_n, 4'b0111);
    dec_if.carry_n = 1'b1;
    #1;
    check("jnc not taken", dec_if.load_n, 4'b1111);
    check("jnc select", {2'b00, dec_if.select}, 4'b0011);

    // Undefined opcode sets the sticky flag; reset clears it without a clock edge.
    @(negedge clk);
    reset = 1'b0;
    drive(4'b1010, 1'b0);
    #1;
    check("undef load_n", dec_if.load_n, 4'b1111);
    check("undef select", {2'b00, dec_if.select}, 4'b0011);
    check("undef illegal before edge", {3'b000, dec_if.illegal}, 4'b0000);
    @(posedge clk);
    #1;
    check("illegal after edge", {3'b000, dec_if.illegal}, 4'b0001);
    @(negedge clk);
    drive(4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check("illegal sticky", {3'b000, dec_if.illegal}, 4'b0001);
`ifdef TD4_DECODER_ILLEGAL_TRAP_EN
    check("trap load_n", dec_if.load_n, 4'b1111);
`else
    check("post-undef load_n", dec_if.load_n, 4'b1110);
`endif
    check("post-undef select", {2'b00, dec_if.select}, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    check("async reset illegal", {3'b000, dec_if.illegal}, 4'b0000);
    check("decode during reset", dec_if.load_n, 4'b1110);
    @(negedge clk);
    reset = 1'b0;

    // Random stimulus against the reference model, with occasional mid-cycle reset pulses.
    exp_illegal = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      logic       c;
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
      drive(op, c);
      #1;
      exp_q.push_back({ref_decode(op, c), exp_illegal});
      check_all("rand comb");
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        #1;
        exp_illegal = 1'b0;
        exp_q.push_back({ref_decode(op, c), 1'b0});
        check_all("rand reset");
        reset = 1'b0;
      end
      @(posedge clk);
      if (!is_defined(op)) exp_illegal = 1'b1;
      #1;
      check("rand illegal", {3'b000, dec_if.illegal}, {3'b000, exp_illegal});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
